// File: rtl/sata_rxfis_decode_if.sv
// ---------------------------------------------------------------------------
// sata_rxfis_decode_if
// Word stream with valid/ready handshake, end-of-frame marker and abort flag.
// The same interface carries the incoming FIS stream (decoder is the slave)
// and the outgoing Data FIS payload stream (decoder is the master).
//
//   valid  master->slave  word valid
//   ready  slave->master  word accepted when valid & ready
//   data   master->slave  32-bit word, FIS byte 0 in data[31:24]
//   last   master->slave  last word of the frame
//   abort  master->slave  input side: frame aborted (qualified by valid)
//                         output side: 1-cycle pulse, discard partial payload
// ---------------------------------------------------------------------------
interface sata_rxfis_decode_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;
  logic        abort;

  modport master (output valid, output data, output last, output abort, input ready);
  modport slave  (input valid, input data, input last, input abort, output ready);
endinterface

// File: rtl/sata_rxfis_decode.sv
// ---------------------------------------------------------------------------
// sata_rxfis_decode
// Host-side receive FIS decoder. Classifies each incoming FIS by its type byte:
//   0x34 Register D2H : fields shadowed, committed to o_reg_* with o_reg_valid
//   0x39 DMA Activate : o_dma_act pulse
//   0x46 Data         : header stripped, payload forwarded on stream m
// Malformed or aborted frames raise o_err_valid with a code in o_err_code:
//   1 unknown type, 2 short FIS, 3 long FIS, 4 abort, 5 empty Data FIS
//
// Ports
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   s                    incoming FIS word stream (slave)
//   m                    Data FIS payload stream (master), m.abort = discard pulse
//   o_reg_valid          pulse: complete Register D2H FIS received
//   o_reg_status/error/device/lba/count   latched Register D2H fields
//   o_dma_act            pulse: DMA Activate received
//   o_err_valid          pulse: error detected
//   o_err_code           code of the most recent error
//
// States
//   state | meaning
//   HDR   | waiting for the first word of a FIS
//   REG   | collecting Register D2H words 1..4
//   DATA  | forwarding Data FIS payload
//   LONG  | frame overran its length; drop to s.last, then error 3
//   DROP  | unknown type already flagged; drop to s.last silently
// ---------------------------------------------------------------------------
module sata_rxfis_decode #(
  parameter int MAX_DATA_WORDS = 2048
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  sata_rxfis_decode_if.slave   s,
  sata_rxfis_decode_if.master  m,
  output logic                 o_reg_valid,
  output logic [7:0]           o_reg_status,
  output logic [7:0]           o_reg_error,
  output logic [7:0]           o_reg_device,
  output logic [47:0]          o_reg_lba,
  output logic [15:0]          o_reg_count,
  output logic                 o_dma_act,
  output logic                 o_err_valid,
  output logic [2:0]           o_err_code
);

  localparam logic [7:0]  TYPE_REG  = 8'h34;
  localparam logic [7:0]  TYPE_DMA  = 8'h39;
  localparam logic [7:0]  TYPE_DATA = 8'h46;
  localparam logic [11:0] DATA_LAST = 12'(MAX_DATA_WORDS - 1);

  localparam logic [2:0] ERR_TYPE  = 3'd1;
  localparam logic [2:0] ERR_SHORT = 3'd2;
  localparam logic [2:0] ERR_LONG  = 3'd3;
  localparam logic [2:0] ERR_ABORT = 3'd4;
  localparam logic [2:0] ERR_EMPTY = 3'd5;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_REG  = 3'd1,
    ST_DATA = 3'd2,
    ST_LONG = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;

  logic [7:0]  sh_status_q, sh_status_d;
  logic [7:0]  sh_error_q,  sh_error_d;
  logic [7:0]  sh_device_q, sh_device_d;
  logic [47:0] sh_lba_q,    sh_lba_d;
  logic [15:0] sh_count_q,  sh_count_d;

  logic [7:0]  reg_status_q, reg_status_d;
  logic [7:0]  reg_error_q,  reg_error_d;
  logic [7:0]  reg_device_q, reg_device_d;
  logic [47:0] reg_lba_q,    reg_lba_d;
  logic [15:0] reg_count_q,  reg_count_d;
  logic        reg_valid_q,  reg_valid_d;

  logic        dma_act_q, dma_act_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q,  m_data_d;
  logic        m_last_q,  m_last_d;
  logic        m_abort_q, m_abort_d;

  logic        s_ready;
  logic        acc;
  logic        take_abort;
  logic        cnt_at_max;
  logic [7:0]  hdr_type;

  // Only the payload path can stall; every other state swallows words freely.
  assign s_ready    = (state_q == ST_DATA) ? (!m_valid_q || m.ready) : 1'b1;
  assign acc        = s.valid && s_ready;
  assign take_abort = acc && s.abort && (state_q != ST_HDR);
  assign cnt_at_max = (cnt_q == DATA_LAST);
  assign hdr_type   = s.data[31:24];

  // -------------------------------------------------------------------------
  // State register (and all other flops)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_HDR;
      cnt_q        <= '0;
      sh_status_q  <= '0;
      sh_error_q   <= '0;
      sh_device_q  <= '0;
      sh_lba_q     <= '0;
      sh_count_q   <= '0;
      reg_status_q <= '0;
      reg_error_q  <= '0;
      reg_device_q <= '0;
      reg_lba_q    <= '0;
      reg_count_q  <= '0;
      reg_valid_q  <= 1'b0;
      dma_act_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_abort_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_status_q  <= sh_status_d;
      sh_error_q   <= sh_error_d;
      sh_device_q  <= sh_device_d;
      sh_lba_q     <= sh_lba_d;
      sh_count_q   <= sh_count_d;
      reg_status_q <= reg_status_d;
      reg_error_q  <= reg_error_d;
      reg_device_q <= reg_device_d;
      reg_lba_q    <= reg_lba_d;
      reg_count_q  <= reg_count_d;
      reg_valid_q  <= reg_valid_d;
      dma_act_q    <= dma_act_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_abort_q    <= m_abort_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (take_abort) begin
      state_d = ST_HDR;
    end else if (acc) begin
      case (state_q)
        ST_HDR: begin
          if (!s.abort) begin
            case (hdr_type)
              TYPE_REG:  state_d = s.last ? ST_HDR : ST_REG;
              TYPE_DMA:  state_d = s.last ? ST_HDR : ST_LONG;
              TYPE_DATA: state_d = s.last ? ST_HDR : ST_DATA;
              default:   state_d = s.last ? ST_HDR : ST_DROP;
            endcase
          end
        end
        ST_REG: begin
          if (s.last)               state_d = ST_HDR;
          else if (cnt_q == 12'd4)  state_d = ST_LONG;
        end
        ST_DATA: begin
          if (s.last)          state_d = ST_HDR;
          else if (cnt_at_max) state_d = ST_LONG;
        end
        ST_LONG, ST_DROP: begin
          if (s.last) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    logic       err_fire;
    logic [2:0] err_new;

    err_fire     = 1'b0;
    err_new      = '0;
    cnt_d        = cnt_q;
    sh_status_d  = sh_status_q;
    sh_error_d   = sh_error_q;
    sh_device_d  = sh_device_q;
    sh_lba_d     = sh_lba_q;
    sh_count_d   = sh_count_q;
    reg_status_d = reg_status_q;
    reg_error_d  = reg_error_q;
    reg_device_d = reg_device_q;
    reg_lba_d    = reg_lba_q;
    reg_count_d  = reg_count_q;
    reg_valid_d  = 1'b0;
    dma_act_d    = 1'b0;
    m_abort_d    = 1'b0;
    // Output word holds until taken; a fresh load below overrides the clear.
    m_valid_d    = m_valid_q && !m.ready;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;

    if (take_abort) begin
      err_fire = 1'b1;
      err_new  = ERR_ABORT;
      cnt_d    = '0;
      if (state_q == ST_DATA) begin
        m_valid_d = 1'b0;
        // With one cycle of latency, a non-zero count means a word was shown.
        m_abort_d = (cnt_q != 12'd0);
      end
    end else if (acc) begin
      case (state_q)
        ST_HDR: begin
          if (!s.abort) begin
            cnt_d = '0;
            case (hdr_type)
              TYPE_REG: begin
                if (s.last) begin
                  err_fire = 1'b1;
                  err_new  = ERR_SHORT;
                end else begin
                  cnt_d       = 12'd1;
                  sh_status_d = s.data[15:8];
                  sh_error_d  = s.data[7:0];
                end
              end
              TYPE_DMA: begin
                dma_act_d = s.last;
              end
              TYPE_DATA: begin
                if (s.last) begin
                  err_fire = 1'b1;
                  err_new  = ERR_EMPTY;
                end
              end
              default: begin
                err_fire = 1'b1;
                err_new  = ERR_TYPE;
              end
            endcase
          end
        end
        ST_REG: begin
          cnt_d = cnt_q + 12'd1;
          case (cnt_q)
            12'd1: begin
              sh_lba_d[7:0]   = s.data[31:24];
              sh_lba_d[15:8]  = s.data[23:16];
              sh_lba_d[23:16] = s.data[15:8];
              sh_device_d     = s.data[7:0];
            end
            12'd2: begin
              sh_lba_d[31:24] = s.data[31:24];
              sh_lba_d[39:32] = s.data[23:16];
              sh_lba_d[47:40] = s.data[15:8];
            end
            12'd3: begin
              sh_count_d[7:0]  = s.data[31:24];
              sh_count_d[15:8] = s.data[23:16];
            end
            default: ;
          endcase
          if (s.last) begin
            if (cnt_q == 12'd4) begin
              reg_valid_d  = 1'b1;
              reg_status_d = sh_status_q;
              reg_error_d  = sh_error_q;
              reg_device_d = sh_device_q;
              reg_lba_d    = sh_lba_q;
              reg_count_d  = sh_count_q;
            end else begin
              err_fire = 1'b1;
              err_new  = ERR_SHORT;
            end
          end
        end
        ST_DATA: begin
          m_valid_d = 1'b1;
          m_data_d  = s.data;
          m_last_d  = s.last || cnt_at_max;
          cnt_d     = cnt_q + 12'd1;
        end
        ST_LONG: begin
          if (s.last) begin
            err_fire = 1'b1;
            err_new  = ERR_LONG;
          end
        end
        default: ;
      endcase
    end

    err_valid_d = err_fire;
    err_code_d  = err_fire ? err_new : err_code_q;
  end

  assign s.ready      = s_ready;
  assign m.valid      = m_valid_q;
  assign m.data       = m_data_q;
  assign m.last       = m_last_q;
  assign m.abort      = m_abort_q;

  assign o_reg_valid  = reg_valid_q;
  assign o_reg_status = reg_status_q;
  assign o_reg_error  = reg_error_q;
  assign o_reg_device = reg_device_q;
  assign o_reg_lba    = reg_lba_q;
  assign o_reg_count  = reg_count_q;
  assign o_dma_act    = dma_act_q;
  assign o_err_valid  = err_valid_q;
  assign o_err_code   = err_code_q;

endmodule

// File: tb/tb_sata_rxfis_decode.sv
module tb_sata_rxfis_decode;
  localparam int MAXW = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sata_rxfis_decode_if s_if ();
  sata_rxfis_decode_if m_if ();

  logic        o_reg_valid;
  logic [7:0]  o_reg_status, o_reg_error, o_reg_device;
  logic [47:0] o_reg_lba;
  logic [15:0] o_reg_count;
  logic        o_dma_act, o_err_valid;
  logic [2:0]  o_err_code;

  sata_rxfis_decode #(.MAX_DATA_WORDS(MAXW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .s(s_if), .m(m_if),
    .o_reg_valid(o_reg_valid), .o_reg_status(o_reg_status), .o_reg_error(o_reg_error),
    .o_reg_device(o_reg_device), .o_reg_lba(o_reg_lba), .o_reg_count(o_reg_count),
    .o_dma_act(o_dma_act), .o_err_valid(o_err_valid), .o_err_code(o_err_code)
  );

  typedef struct { logic [31:0] d; logic l; int id; } wexp_t;

  wexp_t       exp_w[$];
  logic [87:0] exp_reg[$];
  logic [2:0]  exp_err[$];
  int          exp_dma = 0;
  int          exp_mab[$];
  logic [87:0] last_reg = '0;

  int n_cmp = 0;
  int n_fail = 0;
  int fid = 0;

  logic [31:0] fw[$];
  int          fab = -1;
  logic        rdy_auto = 1'b0;

  // ---------------- reference model: spec-level frame outcome ----------------
  task automatic model_frame();
    int n;
    logic [7:0] t;
    n = fw.size();
    t = fw[0][31:24];
    fid++;
    if (t == 8'h46) begin
      int p;
      int dl;
      p  = (fab >= 0) ? fab - 1 : n - 1;
      dl = (p > MAXW) ? MAXW : p;
      if (fab < 0 && n == 1) exp_err.push_back(3'd5);
      else begin
        for (int k = 1; k <= dl; k++) begin
          wexp_t e;
          e.d = fw[k]; e.l = (fab < 0) && (k == dl); e.id = fid;
          exp_w.push_back(e);
        end
        if (fab >= 0) begin
          if (p >= 1) exp_mab.push_back(fid);
          exp_err.push_back(3'd4);
        end else if (p > MAXW) exp_err.push_back(3'd3);
      end
    end else if (t == 8'h34) begin
      if (fab >= 0) exp_err.push_back(3'd4);
      else if (n == 5) begin
        logic [87:0] r;
        r = {fw[0][15:8], fw[0][7:0], fw[1][7:0],
             fw[2][15:8], fw[2][23:16], fw[2][31:24],
             fw[1][15:8], fw[1][23:16], fw[1][31:24],
             fw[3][23:16], fw[3][31:24]};
        exp_reg.push_back(r);
        last_reg = r;
      end else if (n < 5) exp_err.push_back(3'd2);
      else exp_err.push_back(3'd3);
    end else if (t == 8'h39) begin
      if (fab >= 0) exp_err.push_back(3'd4);
      else if (n == 1) exp_dma++;
      else exp_err.push_back(3'd3);
    end else begin
      exp_err.push_back(3'd1);
      if (fab >= 0) exp_err.push_back(3'd4);
    end
  endtask

  // ---------------- driver ----------------
  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "stopped on timeout");
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic a);
    int cyc;
    s_if.valid = 1'b1; s_if.data = d; s_if.last = l; s_if.abort = a;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (s_if.ready) break;
      cyc++;
      if (cyc > 2000) begin
        n_cmp++; n_fail++;
        $display("FAIL s_ready_timeout: word %h not accepted in 2000 cycles (required accept)", d);
        finish_now();
      end
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0; s_if.last = 1'b0; s_if.abort = 1'b0;
  endtask

  task automatic drive_frame(input int gapmax);
    for (int i = 0; i < fw.size(); i++) begin
      if (i == fab) begin
        send_word(fw[i], i == fw.size() - 1, 1'b1);
        break;
      end
      send_word(fw[i], i == fw.size() - 1, 1'b0);
      repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input int gapmax);
    model_frame();
    drive_frame(gapmax);
  endtask

  task automatic set_frame(input logic [7:0] t, input int n);
    logic [31:0] h;
    fw.delete();
    h = $urandom; h[31:24] = t;
    fw.push_back(h);
    for (int i = 1; i < n; i++) fw.push_back($urandom);
  endtask

  task automatic gen_frame();
    int sel;
    int n;
    logic [7:0] t;
    sel = $urandom_range(0, 3);
    case (sel)
      0: begin t = 8'h34; n = $urandom_range(2, 7); end
      1: begin t = 8'h39; n = $urandom_range(1, 3); end
      2: begin t = 8'h46; n = $urandom_range(1, 9); end
      default: begin
        t = 8'($urandom);
        while (t == 8'h34 || t == 8'h39 || t == 8'h46) t = 8'($urandom);
        n = $urandom_range(1, 4);
      end
    endcase
    set_frame(t, n);
    fab = (n >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_w.size() != 0 || exp_reg.size() != 0 || exp_err.size() != 0 ||
            exp_dma != 0 || exp_mab.size() != 0) && i < 20000) begin
      @(posedge clk); i++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_w.size() + exp_reg.size() + exp_err.size() + exp_dma + exp_mab.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending words=%0d reg=%0d err=%0d dma=%0d mabort=%0d, required all 0",
               exp_w.size(), exp_reg.size(), exp_err.size(), exp_dma, exp_mab.size());
      exp_w.delete(); exp_reg.delete(); exp_err.delete(); exp_mab.delete(); exp_dma = 0;
    end
  endtask

  // ---------------- m_ready generator ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_auto) m_if.ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.valid && m_if.ready) begin
        n_cmp++;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL payload_extra: got data=%h last=%b, required no word", m_if.data, m_if.last);
        end else begin
          wexp_t e;
          e = exp_w.pop_front();
          if ({m_if.data, m_if.last} !== {e.d, e.l}) begin
            n_fail++;
            $display("FAIL payload: got data=%h last=%b, required data=%h last=%b",
                     m_if.data, m_if.last, e.d, e.l);
          end
        end
      end
      if (m_if.abort) begin
        n_cmp++;
        if (exp_mab.size() == 0) begin
          n_fail++;
          $display("FAIL m_abort: got pulse, required none");
        end else begin
          int aid;
          aid = exp_mab.pop_front();
          while (exp_w.size() != 0 && exp_w[0].id == aid) void'(exp_w.pop_front());
        end
      end
      if (o_reg_valid) begin
        n_cmp++;
        if (exp_reg.size() == 0) begin
          n_fail++;
          $display("FAIL reg_valid: got unexpected pulse, required none");
        end else begin
          logic [87:0] r;
          r = exp_reg.pop_front();
          if ({o_reg_status, o_reg_error, o_reg_device, o_reg_lba, o_reg_count} !== r) begin
            n_fail++;
            $display("FAIL reg_fields: got %h, required %h",
                     {o_reg_status, o_reg_error, o_reg_device, o_reg_lba, o_reg_count}, r);
          end
        end
      end
      if (o_dma_act) begin
        n_cmp++;
        if (exp_dma == 0) begin
          n_fail++;
          $display("FAIL dma_act: got unexpected pulse, required none");
        end else exp_dma--;
      end
      if (o_err_valid) begin
        n_cmp++;
        if (exp_err.size() == 0) begin
          n_fail++;
          $display("FAIL err: got code %0d, required no error", o_err_code);
        end else begin
          logic [2:0] c;
          c = exp_err.pop_front();
          if (o_err_code !== c) begin
            n_fail++;
            $display("FAIL err_code: got %0d, required %0d", o_err_code, c);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; s_if.abort = 1'b0;
    m_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_if.valid, m_if.last, m_if.abort, m_if.data, o_reg_valid, o_reg_status, o_reg_error,
         o_reg_device, o_reg_lba, o_reg_count, o_dma_act, o_err_valid, o_err_code} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs after reset, required all 0");
    end
    @(posedge clk); #1;
    m_if.ready = 1'b1;

    // 1: Register D2H
    fw = '{32'h3450_7700, 32'h1122_33E0, 32'h4455_6600, 32'h0800_0000, 32'h0000_0000};
    fab = -1; run_frame(0); drain();
    n_cmp++;
    if ({o_reg_lba, o_reg_count, o_reg_device} !== {48'h665544_332211, 16'h0008, 8'hE0}) begin
      n_fail++;
      $display("FAIL reg_vector: got lba=%h count=%h device=%h, required 665544332211 0008 e0",
               o_reg_lba, o_reg_count, o_reg_device);
    end

    // 2: DMA Activate
    fw = '{32'h3900_0000}; fab = -1; run_frame(0); drain();

    // 3: Data FIS with a 3-cycle downstream stall
    rdy_auto = 1'b0;
    m_if.ready = 1'b0;
    fw = '{32'h4600_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    fab = -1;
    model_frame();
    send_word(fw[0], 1'b0, 1'b0);
    send_word(fw[1], 1'b0, 1'b0);
    s_if.valid = 1'b1; s_if.data = fw[2]; s_if.last = 1'b0; s_if.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({s_if.ready, m_if.valid} !== 2'b01) begin
        n_fail++;
        $display("FAIL stall: got s_ready=%b m_valid=%b, required s_ready=0 m_valid=1",
                 s_if.ready, m_if.valid);
      end
    end
    @(posedge clk); #1;
    m_if.ready = 1'b1;
    send_word(fw[2], 1'b0, 1'b0);
    send_word(fw[3], 1'b0, 1'b0);
    send_word(fw[4], 1'b1, 1'b0);
    drain();
    rdy_auto = 1'b1;

    // 4: abort on payload word 3, then a Register FIS
    fw = '{32'h4600_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    fab = 3; run_frame(0);
    set_frame(8'h34, 5); fab = -1; run_frame(1); drain();

    // 5: unknown type, then short Register FIS leaving o_reg_* unchanged
    set_frame(8'h27, 3); fab = -1; run_frame(1);
    set_frame(8'h34, 3); fab = -1; run_frame(1); drain();
    n_cmp++;
    if ({o_reg_status, o_reg_error, o_reg_device, o_reg_lba, o_reg_count} !== last_reg) begin
      n_fail++;
      $display("FAIL reg_hold: got %h, required %h",
               {o_reg_status, o_reg_error, o_reg_device, o_reg_lba, o_reg_count}, last_reg);
    end

    // 6: payload length at and beyond MAX_DATA_WORDS
    set_frame(8'h46, MAXW + 1); fab = -1; run_frame(0); drain();
    set_frame(8'h46, MAXW + 2); fab = -1; run_frame(0); drain();
    set_frame(8'h46, MAXW + 3); fab = -1; run_frame(0); drain();

    // random traffic
    for (int f = 0; f < 300; f++) begin
      gen_frame();
      run_frame(2);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
